// File: rtl/rcc_pkg.sv
// Constants shared by the frame loader and the conversion block's holding-register header.
// Covers register addresses, the go command address and the FSM state encodings.
package rcc_pkg;

    localparam logic [3:0] RCC_ADDR [0:7] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    localparam logic [3:0] RCC_ADDR_GO    = 4'h8;
    localparam logic [3:0] RCC_GO_INDEX   = 4'd8;

    // Frame loader top-level states; ST_WRITE covers the SETUP/STROBE/HOLD sequence.
    localparam logic [1:0] ST_COLLECT  = 2'd0;
    localparam logic [1:0] ST_GAP_WAIT = 2'd1;
    localparam logic [1:0] ST_WRITE    = 2'd2;

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;
    localparam logic [1:0] PH_STROBE = 2'd2;
    localparam logic [1:0] PH_HOLD   = 2'd3;

    function automatic logic [3:0] rcc_write_addr(input logic [3:0] wr);
        return (wr == RCC_GO_INDEX) ? RCC_ADDR_GO : RCC_ADDR[wr[2:0]];
    endfunction

endpackage

// File: rtl/rcc_strobe_gen.sv
// Drives one holding-register write: SETUP (strobe low), STROBE_HI clocks high, HOLD (low).
// A start seen in HOLD chains straight into the next write's SETUP.
module rcc_strobe_gen
    import rcc_pkg::*;
#(
    parameter int DW        = 16,
    parameter int STROBE_HI = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic [3:0]    i_address,
    input  logic [DW-1:0] i_data,
    output logic          o_rcc_clk,
    output logic [3:0]    o_address,
    output logic [DW-1:0] o_din,
    output logic          o_done
);

    localparam int            CW      = (STROBE_HI > 1) ? $clog2(STROBE_HI) : 1;
    localparam logic [CW-1:0] HI_LAST = CW'(STROBE_HI - 1);

    logic [1:0]    r_phase;
    logic [CW-1:0] r_hiCnt;
    logic          r_rccClk;
    logic [3:0]    r_address;
    logic [DW-1:0] r_din;

    // Address/data latch only on start, so they stay put between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase   <= PH_IDLE;
            r_hiCnt   <= '0;
            r_rccClk  <= 1'b0;
            r_address <= '0;
            r_din     <= '0;
        end else begin
            case (r_phase)
                PH_IDLE, PH_HOLD: begin
                    if (i_start) begin
                        r_address <= i_address;
                        r_din     <= i_data;
                        r_phase   <= PH_SETUP;
                    end else begin
                        r_phase   <= PH_IDLE;
                    end
                end
                PH_SETUP: begin
                    r_rccClk <= 1'b1;
                    r_hiCnt  <= '0;
                    r_phase  <= PH_STROBE;
                end
                PH_STROBE: begin
                    if (r_hiCnt == HI_LAST) begin
                        r_rccClk <= 1'b0;
                        r_phase  <= PH_HOLD;
                    end else begin
                        r_hiCnt  <= r_hiCnt + CW'(1);
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

    assign o_rcc_clk = r_rccClk;
    assign o_address = r_address;
    assign o_din     = r_din;
    assign o_done    = (r_phase == PH_HOLD);

endmodule

// File: rtl/rcc_frame_loader.sv
// Buffers one eight-bin magnitude frame and writes it plus a go command into the
// conversion block, keeping consecutive go-writes at least MIN_FRAME_GAP clocks apart.
module rcc_frame_loader
    import rcc_pkg::*;
#(
    parameter int DW            = 16,
    parameter int STROBE_HI     = 2,
    parameter int MIN_FRAME_GAP = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          rcc_clk,
    output logic [3:0]    address,
    output logic [DW-1:0] din,
    output logic          busy,
    output logic          err_frame,
    output logic [7:0]    frame_count
);

    localparam int            GW      = $clog2(MIN_FRAME_GAP + 1);
    localparam logic [GW-1:0] GAP_MIN = GW'(MIN_FRAME_GAP);

    logic [1:0]    r_state;
    logic [2:0]    r_idx;
    logic [3:0]    r_wr;
    logic [GW-1:0] r_gapCnt;
    logic          r_errFrame;
    logic [7:0]    r_frameCount;
    logic [DW-1:0] r_buf [0:7];

    logic          w_handshake;
    logic          w_gapMet;
    logic          w_done;
    logic          w_start;
    logic [3:0]    w_nextWr;
    logic [3:0]    w_wrAddr;
    logic [DW-1:0] w_wrData;

    assign in_ready    = (r_state == ST_COLLECT) && !reset;
    assign w_handshake = in_valid && in_ready;
    assign w_gapMet    = (r_gapCnt >= GAP_MIN);
    assign w_nextWr    = (r_state == ST_GAP_WAIT) ? 4'd0 : r_wr + 4'd1;
    assign w_start     = ((r_state == ST_GAP_WAIT) && w_gapMet) ||
                         ((r_state == ST_WRITE) && w_done && (r_wr != RCC_GO_INDEX));
    assign w_wrAddr    = rcc_write_addr(w_nextWr);
    assign w_wrData    = (w_nextWr == RCC_GO_INDEX) ? '0 : r_buf[w_nextWr[2:0]];

    always_ff @(posedge clk) begin
        if (w_handshake) begin
            r_buf[r_idx] <= in_data;
        end
    end

    // The gap counter only runs while no write is in flight; the go-write's HOLD restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_COLLECT;
            r_idx        <= '0;
            r_wr         <= '0;
            r_gapCnt     <= GAP_MIN;
            r_errFrame   <= 1'b0;
            r_frameCount <= '0;
        end else begin
            r_errFrame <= 1'b0;
            if ((r_state != ST_WRITE) && (r_gapCnt < GAP_MIN)) begin
                r_gapCnt <= r_gapCnt + GW'(1);
            end
            case (r_state)
                ST_COLLECT: begin
                    if (w_handshake) begin
                        if ((r_idx == 3'd7) && in_last) begin
                            r_idx   <= '0;
                            r_state <= ST_GAP_WAIT;
                        end else if (in_last || (r_idx == 3'd7)) begin
                            r_idx      <= '0;
                            r_errFrame <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                ST_GAP_WAIT: begin
                    if (w_gapMet) begin
                        r_wr    <= '0;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_done) begin
                        if (r_wr == RCC_GO_INDEX) begin
                            r_frameCount <= r_frameCount + 8'd1;
                            r_gapCnt     <= '0;
                            r_state      <= ST_COLLECT;
                        end else begin
                            r_wr <= w_nextWr;
                        end
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

    rcc_strobe_gen #(
        .DW        (DW),
        .STROBE_HI (STROBE_HI)
    ) u_strobe (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_start),
        .i_address (w_wrAddr),
        .i_data    (w_wrData),
        .o_rcc_clk (rcc_clk),
        .o_address (address),
        .o_din     (din),
        .o_done    (w_done)
    );

    assign busy        = (r_state != ST_COLLECT);
    assign err_frame   = r_errFrame;
    assign frame_count = r_frameCount;

endmodule

// File: tb/tb_rcc_frame_loader.sv
// Scoreboard bench for rcc_frame_loader: stimulus pushes expected writes, a negedge monitor
// pops and checks every strobe, its width, go-write pacing and first-write latency.
module tb_rcc_frame_loader;

    localparam int DW            = 16;
    localparam int STROBE_HI     = 2;
    localparam int MIN_FRAME_GAP = 64;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready;
    logic          rcc_clk;
    logic [3:0]    address;
    logic [DW-1:0] din;
    logic          busy;
    logic          err_frame;
    logic [7:0]    frame_count;

    rcc_frame_loader #(
        .DW            (DW),
        .STROBE_HI     (STROBE_HI),
        .MIN_FRAME_GAP (MIN_FRAME_GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .rcc_clk     (rcc_clk),
        .address     (address),
        .din         (din),
        .busy        (busy),
        .err_frame   (err_frame),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int            nCompared   = 0;
    int            nMismatched = 0;
    logic [19:0]   expQ[$];
    int            expFrames   = 0;
    int            expErr      = 0;
    logic [DW-1:0] frameData [0:7];
    logic [DW-1:0] nominal   [0:7];

    int          cyc        = 0;
    logic        prevRcc    = 1'b0;
    logic        prevErr    = 1'b0;
    int          errRun     = 0;
    int          errSeen    = 0;
    int          highCnt    = 0;
    logic [19:0] riseWord   = '0;
    int          wIdx       = 0;
    int          lastHs     = -1;
    int          lastGoFall = 0;
    bit          goSince    = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: all DUT outputs sampled on the falling clock edge.
    always @(negedge clk) begin
        int expLat;
        logic [19:0] expWord;
        cyc = cyc + 1;
        if (reset) begin
            expQ.delete();
            wIdx    = 0;
            goSince = 1'b0;
            prevRcc = 1'b0;
            prevErr = 1'b0;
            errRun  = 0;
            highCnt = 0;
            lastHs  = -1;
        end else begin
            if (busy) checkOutput("in_ready_while_busy", 64'(in_ready), 64'd0);
            if (in_valid && in_ready && in_last) lastHs = cyc;

            if (err_frame) begin
                if (!prevErr) errSeen++;
                errRun++;
            end else if (prevErr) begin
                checkOutput("err_frame_width", 64'(errRun), 64'd1);
                errRun = 0;
            end
            prevErr = err_frame;

            if (rcc_clk && !prevRcc) begin
                riseWord = {address, din};
                highCnt  = 1;
                if (wIdx == 0) begin
                    if (lastHs < 0) begin
                        nCompared++;
                        nMismatched++;
                        $display("[TB] FAIL write_without_frame: got strobe at addr %0h, expected none", address);
                    end else begin
                        expLat = lastHs + 3;
                        if (goSince && (lastGoFall + MIN_FRAME_GAP + 3 > expLat))
                            expLat = lastGoFall + MIN_FRAME_GAP + 3;
                        checkOutput("first_write_rise_cycle", 64'(cyc), 64'(expLat));
                    end
                end
                if ((wIdx == 8) && goSince)
                    checkOutput("go_gap_ok", 64'((cyc - lastGoFall) >= MIN_FRAME_GAP), 64'd1);
            end else if (rcc_clk) begin
                highCnt++;
            end

            if (!rcc_clk && prevRcc) begin
                checkOutput("strobe_high_clks", 64'(highCnt), 64'(STROBE_HI));
                if (expQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL unexpected_write: got addr %0h din %0h, expected no write", address, din);
                end else begin
                    expWord = expQ.pop_front();
                    checkOutput("write_word_at_fall", 64'({address, din}), 64'(expWord));
                    checkOutput("write_word_at_rise", 64'(riseWord), 64'(expWord));
                end
                if (wIdx == 8) begin
                    lastGoFall = cyc;
                    goSince    = 1'b1;
                    lastHs     = -1;
                    wIdx       = 0;
                end else begin
                    wIdx++;
                end
            end
            prevRcc = rcc_clk;
        end
    end

    task automatic applyStimulus(input int nBeats, input int lastPos, input int maxIdle);
        int idle;
        int t;
        bit ok;
        for (int b = 0; b < nBeats; b++) begin
            idle     = (maxIdle > 0) ? int'($urandom_range(maxIdle, 0)) : 0;
            in_valid = 1'b0;
            in_last  = 1'b0;
            repeat (idle) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = frameData[b];
            in_last  = (b == lastPos);
            ok = 1'b0;
            t  = 0;
            while (!ok && t < 3000) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!ok) checkOutput("handshake_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic randomFrame();
        for (int i = 0; i < 8; i++) frameData[i] = DW'($urandom);
    endtask

    // A well-framed frame must produce bins 0..7 at addresses 0..7, then the go command.
    task automatic sendGoodFrame(input int maxIdle);
        for (int i = 0; i < 8; i++) expQ.push_back({4'(i), frameData[i]});
        expQ.push_back({4'h8, 16'h0000});
        expFrames++;
        applyStimulus(8, 7, maxIdle);
    endtask

    task automatic waitDrain(input string tag);
        int t;
        t = 0;
        while ((expQ.size() != 0 || busy) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        checkOutput({tag, "_drained"}, 64'(expQ.size() == 0 && !busy), 64'd1);
        repeat (2) @(negedge clk);
        #1;
        checkOutput({tag, "_frame_count"}, 64'(frame_count), 64'(8'(expFrames)));
        checkOutput({tag, "_err_pulses"}, 64'(errSeen), 64'(expErr));
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rcc_clk", 64'(rcc_clk), 64'd0);
        checkOutput("reset_address", 64'(address), 64'd0);
        checkOutput("reset_din", 64'(din), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_err_frame", 64'(err_frame), 64'd0);
        checkOutput("reset_frame_count", 64'(frame_count), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        expFrames = 0;
        @(negedge clk);
        checkOutput("in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        nominal = '{16'd100, 16'd20, 16'd20, 16'd20, 16'd20, 16'd300, 16'd20, 16'd20};

        applyReset();

        for (int i = 0; i < 8; i++) frameData[i] = nominal[i];
        sendGoodFrame(0);
        waitDrain("nominal");

        randomFrame();
        sendGoodFrame(0);
        randomFrame();
        sendGoodFrame(0);
        waitDrain("back_to_back");

        randomFrame();
        applyStimulus(5, 4, 0);
        expErr++;
        waitDrain("early_last");
        randomFrame();
        sendGoodFrame(0);
        waitDrain("after_early_last");

        randomFrame();
        applyStimulus(8, -1, 2);
        expErr++;
        waitDrain("missing_last");

        for (int i = 0; i < 8; i++) frameData[i] = nominal[i];
        sendGoodFrame(5);
        for (int f = 0; f < 3; f++) begin
            randomFrame();
            sendGoodFrame(5);
        end
        waitDrain("valid_gaps");

        randomFrame();
        for (int i = 0; i < 8; i++) expQ.push_back({4'(i), frameData[i]});
        applyStimulus(8, 7, 0);
        t = 0;
        while (!(rcc_clk && address == 4'd3) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checkOutput("reached_write3_strobe", 64'(rcc_clk && address == 4'd3), 64'd1);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_rcc_clk", 64'(rcc_clk), 64'd0);
        checkOutput("midreset_address", 64'(address), 64'd0);
        checkOutput("midreset_din", 64'(din), 64'd0);
        checkOutput("midreset_frame_count", 64'(frame_count), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        expFrames = 0;
        @(posedge clk);
        #1;
        randomFrame();
        sendGoodFrame(1);
        waitDrain("after_midreset");

        for (int f = 0; f < 255; f++) begin
            randomFrame();
            sendGoodFrame(0);
        end
        waitDrain("wrap_to_zero");
        randomFrame();
        sendGoodFrame(0);
        waitDrain("wrap_plus_one");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
